// File: rtl/shift_reg_univ_pkg.sv
// Shared definitions for the universal shift register.
//   - Opcode encodings for the per-cycle operation select.
//   - cnt_width(): width of a counter that must be able to hold WIDTH.
package shift_reg_univ_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  // Bits needed to represent the values 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_reg_univ.sv
// Universal shift register with a shift counter and a frame-complete pulse.
// Usable directly as a serializer (sample sout_* before the shifting edge)
// or as a deserializer (read q in the cycle frame_done is high).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides en/op)
//   en         clock enable; 0 holds q and shift_cnt, clears frame_done
//   op         operation select (OP_* in shift_reg_univ_pkg)
//   sin_r      serial in, enters the MSB on SHR
//   sin_l      serial in, enters the LSB on SHL
//   pdata      parallel load data
//   q          register contents
//   sout_r     q[0], the bit leaving on a right shift
//   sout_l     q[WIDTH-1], the bit leaving on a left shift
//   shift_cnt  shifts/rotates since last load/clear/frame wrap
//   frame_done one-cycle pulse when WIDTH shifts have completed
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [2:0]                    op,
  input  logic                          sin_r,
  input  logic                          sin_l,
  input  logic [WIDTH-1:0]              pdata,
  output logic [WIDTH-1:0]              q,
  output logic                          sout_r,
  output logic                          sout_l,
  output logic [cnt_width(WIDTH)-1:0]   shift_cnt,
  output logic                          frame_done
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             frame_reg, frame_next;
  logic             is_shift;

  always_comb begin
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    frame_next = 1'b0;
    is_shift   = 1'b0;

    if (en) begin
      case (op)
        OP_SHR: begin
          q_next   = {sin_r, q_reg[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        OP_SHL: begin
          q_next   = {q_reg[WIDTH-2:0], sin_l};
          is_shift = 1'b1;
        end
        OP_ASR: begin
          q_next   = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        OP_ROR: begin
          q_next   = {q_reg[0], q_reg[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        OP_ROL: begin
          q_next   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
          is_shift = 1'b1;
        end
        OP_LOAD: begin
          q_next   = pdata;
          cnt_next = '0;
        end
        OP_CLR: begin
          q_next   = '0;
          cnt_next = '0;
        end
        default: begin
          q_next = q_reg;
        end
      endcase

      // The counter never holds WIDTH: the WIDTH-th shift wraps straight
      // to zero and raises the pulse in the cycle q shows the full frame.
      if (is_shift) begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          frame_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg     <= RST_VAL;
      cnt_reg   <= '0;
      frame_reg <= 1'b0;
    end else begin
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      frame_reg <= frame_next;
    end
  end

  assign q          = q_reg;
  assign sout_r     = q_reg[0];
  assign sout_l     = q_reg[WIDTH-1];
  assign shift_cnt  = cnt_reg;
  assign frame_done = frame_reg;

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

  localparam logic [2:0] T_HOLD = 3'd0, T_SHR = 3'd1, T_SHL = 3'd2, T_ASR = 3'd3,
                         T_ROR = 3'd4, T_ROL = 3'd5, T_LOAD = 3'd6, T_CLR = 3'd7;

  logic        clk = 1'b0;
  logic        rst, en, sin_r, sin_l;
  logic [2:0]  op;
  logic [1:0]  pdata2;
  logic [7:0]  pdata8;
  logic [32:0] pdata33;

  logic [1:0]  q2;   logic sr2, sl2, fd2;   logic [1:0] cnt2;
  logic [7:0]  q8;   logic sr8, sl8, fd8;   logic [3:0] cnt8;
  logic [32:0] q33;  logic sr33, sl33, fd33; logic [5:0] cnt33;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(2), .RST_VAL(2'b10)) u_w2 (
    .clk(clk), .rst(rst), .en(en), .op(op), .sin_r(sin_r), .sin_l(sin_l),
    .pdata(pdata2), .q(q2), .sout_r(sr2), .sout_l(sl2), .shift_cnt(cnt2),
    .frame_done(fd2));

  shift_reg_univ #(.WIDTH(8), .RST_VAL(8'hA5)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .op(op), .sin_r(sin_r), .sin_l(sin_l),
    .pdata(pdata8), .q(q8), .sout_r(sr8), .sout_l(sl8), .shift_cnt(cnt8),
    .frame_done(fd8));

  shift_reg_univ #(.WIDTH(33), .RST_VAL(33'h1_2345_6789)) u_w33 (
    .clk(clk), .rst(rst), .en(en), .op(op), .sin_r(sin_r), .sin_l(sin_l),
    .pdata(pdata33), .q(q33), .sout_r(sr33), .sout_l(sl33), .shift_cnt(cnt33),
    .frame_done(fd33));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One printed line per directed transaction on the 8-bit instance.
  task automatic step8();
    tick();
    $display("t=%0t rst=%b en=%b op=%0d sin_r=%b sin_l=%b pdata=%h -> q=%h cnt=%0d fd=%b",
             $time, rst, en, op, sin_r, sin_l, pdata8, q8, cnt8, fd8);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; op = T_HOLD; sin_r = 0; sin_l = 0; pdata8 = '0;
    step8();
    total++; if (q8 !== 8'hA5) begin bad++; $display("FAIL reset_q got=%h exp=a5", q8); end
    total++; if (cnt8 !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt8); end
    total++; if (fd8 !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", fd8); end
    // Reset in the middle of a frame.
    rst = 1'b0; en = 1'b1; op = T_LOAD; pdata8 = 8'h12; step8();
    op = T_SHR;
    for (int i = 0; i < 3; i++) step8();
    rst = 1'b1; step8();
    total++; if (q8 !== 8'hA5) begin bad++; $display("FAIL midreset_q got=%h exp=a5", q8); end
    total++; if (cnt8 !== 4'd0) begin bad++; $display("FAIL midreset_cnt got=%0d exp=0", cnt8); end
    total++; if (fd8 !== 1'b0) begin bad++; $display("FAIL midreset_fd got=%b exp=0", fd8); end
    // A reset pulse that never overlaps an edge must do nothing.
    rst = 1'b0; op = T_LOAD; pdata8 = 8'h12; step8();
    en = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step8();
    total++; if (q8 !== 8'h12) begin bad++; $display("FAIL asyncpulse_q got=%h exp=12", q8); end
    total++; if (cnt8 !== 4'd0) begin bad++; $display("FAIL asyncpulse_cnt got=%0d exp=0", cnt8); end
  endtask

  task automatic test_shift_ops();
    logic [7:0] expq;
    logic [2:0] ops [7];
    ops = '{T_SHR, T_SHR, T_SHR, T_SHR, T_ASR, T_ROL, T_ROL};
    en = 1'b1; op = T_LOAD; pdata8 = 8'h81; step8();
    expq = 8'h81;
    sin_r = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op = ops[i];
      case (ops[i])
        T_SHR:   expq = (expq >> 1) | 8'h80;
        T_ASR:   expq = (expq >> 1) | (expq & 8'h80);
        default: expq = (expq << 1) | (expq >> 7);
      endcase
      step8();
      total++; if (q8 !== expq) begin bad++; $display("FAIL shiftops_q step=%0d got=%h exp=%h", i, q8, expq); end
      total++; if (sr8 !== expq[0] || sl8 !== expq[7]) begin
        bad++; $display("FAIL shiftops_sout step=%0d got=%b%b exp=%b%b", i, sl8, sr8, expq[7], expq[0]);
      end
    end
    total++; if (q8 !== 8'hF3) begin bad++; $display("FAIL shiftops_final got=%h exp=f3", q8); end
    sin_r = 1'b0;
  endtask

  task automatic test_deserialize();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    en = 1'b1; op = T_CLR; step8();
    op = T_SHL;
    for (int i = 0; i < 8; i++) begin
      sin_l = bits[7-i];
      step8();
      total++; if (fd8 !== (i == 7)) begin bad++; $display("FAIL deser_fd step=%0d got=%b exp=%b", i, fd8, (i == 7)); end
    end
    total++; if (q8 !== 8'hB2) begin bad++; $display("FAIL deser_q got=%h exp=b2", q8); end
    total++; if (cnt8 !== 4'd0) begin bad++; $display("FAIL deser_cnt got=%0d exp=0", cnt8); end
    sin_l = 1'b0;
  endtask

  task automatic test_serialize();
    logic [7:0] expq;
    en = 1'b1; op = T_LOAD; pdata8 = 8'h3C; step8();
    expq = 8'h3C;
    op = T_SHR; sin_r = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      total++; if (sr8 !== expq[0]) begin bad++; $display("FAIL ser_sout shift=%0d got=%b exp=%b", i, sr8, expq[0]); end
      expq = expq >> 1;
      step8();
      total++; if (fd8 !== (i % 8 == 0)) begin bad++; $display("FAIL ser_fd shift=%0d got=%b exp=%b", i, fd8, (i % 8 == 0)); end
      total++; if (cnt8 !== 4'(i % 8)) begin bad++; $display("FAIL ser_cnt shift=%0d got=%0d exp=%0d", i, cnt8, i % 8); end
    end
  endtask

  task automatic test_load_and_enable();
    logic [7:0] expq;
    en = 1'b1; op = T_LOAD; pdata8 = 8'h00; step8();
    op = T_SHR; sin_r = 1'b1;
    for (int i = 0; i < 7; i++) step8();
    op = T_LOAD; pdata8 = 8'h5A; step8();
    total++; if (q8 !== 8'h5A) begin bad++; $display("FAIL loadwin_q got=%h exp=5a", q8); end
    total++; if (fd8 !== 1'b0) begin bad++; $display("FAIL loadwin_fd got=%b exp=0", fd8); end
    total++; if (cnt8 !== 4'd0) begin bad++; $display("FAIL loadwin_cnt got=%0d exp=0", cnt8); end
    expq = 8'h5A;
    op = T_SHR;
    for (int i = 0; i < 3; i++) begin expq = (expq >> 1) | 8'h80; step8(); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step8();
      total++; if (q8 !== expq) begin bad++; $display("FAIL freeze_q cyc=%0d got=%h exp=%h", i, q8, expq); end
      total++; if (cnt8 !== 4'd3) begin bad++; $display("FAIL freeze_cnt cyc=%0d got=%0d exp=3", i, cnt8); end
      total++; if (fd8 !== 1'b0) begin bad++; $display("FAIL freeze_fd cyc=%0d got=%b exp=0", i, fd8); end
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step8();
      total++; if (fd8 !== (i == 4)) begin bad++; $display("FAIL resume_fd cyc=%0d got=%b exp=%b", i, fd8, (i == 4)); end
    end
    sin_r = 1'b0;
  endtask

  // Reference next-state of a w-bit register held in the low bits of 64.
  function automatic logic [63:0] model_q(input logic [63:0] qv, input int w,
      input logic [2:0] o, input logic sr, input logic sl, input logic [63:0] pd);
    logic [63:0] mask;
    logic        msb;
    mask = (64'd1 << w) - 64'd1;
    msb  = qv[w-1];
    case (o)
      T_SHR:   return (qv >> 1) | (64'(sr) << (w - 1));
      T_SHL:   return ((qv << 1) | 64'(sl)) & mask;
      T_ASR:   return (qv >> 1) | (64'(msb) << (w - 1));
      T_ROR:   return (qv >> 1) | (64'(qv[0]) << (w - 1));
      T_ROL:   return ((qv << 1) | 64'(msb)) & mask;
      T_LOAD:  return pd & mask;
      T_CLR:   return 64'd0;
      default: return qv;
    endcase
  endfunction

  task automatic test_random();
    int          wid [3];
    logic [63:0] rv  [3];
    logic [63:0] mq  [3];
    int          mc  [3];
    logic        mf  [3];
    logic [63:0] dq  [3];
    int          dc  [3];
    logic        df  [3];
    logic        dsr [3];
    logic        dsl [3];
    logic [63:0] pd;
    wid = '{2, 8, 33};
    rv  = '{64'h2, 64'hA5, 64'h1_2345_6789};
    rst = 1'b1; en = 1'b0; op = T_HOLD; tick();
    for (int k = 0; k < 3; k++) begin mq[k] = rv[k]; mc[k] = 0; mf[k] = 1'b0; end
    for (int n = 0; n < 10000; n++) begin
      rst   = ($urandom_range(0, 127) == 0);
      en    = ($urandom_range(0, 7) != 0);
      op    = 3'($urandom_range(0, 7));
      sin_r = 1'($urandom);
      sin_l = 1'($urandom);
      pd    = {$urandom, $urandom};
      pdata2 = pd[1:0]; pdata8 = pd[7:0]; pdata33 = pd[32:0];
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          mq[k] = rv[k]; mc[k] = 0; mf[k] = 1'b0;
        end else if (!en) begin
          mf[k] = 1'b0;
        end else begin
          mq[k] = model_q(mq[k], wid[k], op, sin_r, sin_l, pd);
          mf[k] = 1'b0;
          if (op == T_LOAD || op == T_CLR) mc[k] = 0;
          else if (op != T_HOLD) begin
            mc[k] = mc[k] + 1;
            if (mc[k] == wid[k]) begin mc[k] = 0; mf[k] = 1'b1; end
          end
        end
      end
      tick();
      dq[0] = 64'(q2);  dc[0] = int'(cnt2);  df[0] = fd2;  dsr[0] = sr2;  dsl[0] = sl2;
      dq[1] = 64'(q8);  dc[1] = int'(cnt8);  df[1] = fd8;  dsr[1] = sr8;  dsl[1] = sl8;
      dq[2] = 64'(q33); dc[2] = int'(cnt33); df[2] = fd33; dsr[2] = sr33; dsl[2] = sl33;
      for (int k = 0; k < 3; k++) begin
        total++; if (dq[k] !== mq[k]) begin bad++; $display("FAIL rand_q w=%0d cyc=%0d got=%h exp=%h", wid[k], n, dq[k], mq[k]); end
        total++; if (dc[k] !== mc[k]) begin bad++; $display("FAIL rand_cnt w=%0d cyc=%0d got=%0d exp=%0d", wid[k], n, dc[k], mc[k]); end
        total++; if (df[k] !== mf[k]) begin bad++; $display("FAIL rand_fd w=%0d cyc=%0d got=%b exp=%b", wid[k], n, df[k], mf[k]); end
        total++; if (dsr[k] !== mq[k][0] || dsl[k] !== mq[k][wid[k]-1]) begin
          bad++; $display("FAIL rand_sout w=%0d cyc=%0d got=%b%b exp=%b%b", wid[k], n, dsl[k], dsr[k], mq[k][wid[k]-1], mq[k][0]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = T_HOLD; sin_r = 1'b0; sin_l = 1'b0;
    pdata2 = '0; pdata8 = '0; pdata33 = '0;
    test_reset();
    test_shift_ops();
    test_deserialize();
    test_serialize();
    test_load_and_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
